// File: rtl/sseg_scan_display.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_scan_display
//  Description : Multiplexed seven-segment display driver.
//                A captured binary value is converted to BCD by a serial
//                double-dabble engine (or passed through as hex nibbles),
//                latched into a display register, then scanned across
//                DIGITS positions at a divided refresh rate. Leading-zero
//                blanking, per-digit decimal points, overflow dashes and
//                configurable output polarity are supported.
//
//  Ports       : clk            - system clock, rising edge
//                reset          - asynchronous active-low reset
//                value          - binary value to display (DATA_WIDTH)
//                load           - one-cycle capture request for value/hex_mode
//                hex_mode       - 1 = hexadecimal, 0 = decimal
//                blank_zeros    - 1 = blank leading zeros (live)
//                dp_mask        - decimal point per position (live)
//                busy           - conversion in progress
//                sseg_indicator - {dp,g,f,e,d,c,b,a}, registered
//                digits         - one-hot position select, registered
//
//  Revision    : 1.0 - initial release
// ============================================================================
module sseg_scan_display #(
    parameter int DATA_WIDTH     = 9,
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 1024,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] value,
    input  logic                  load,
    input  logic                  hex_mode,
    input  logic                  blank_zeros,
    input  logic [DIGITS-1:0]     dp_mask,
    output logic                  busy,
    output logic [7:0]            sseg_indicator,
    output logic [DIGITS-1:0]     digits
);

    // ------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------
    // Enough BCD nibbles to hold the largest DATA_WIDTH-bit value.
    localparam int BCD_N  = (DATA_WIDTH * 3) / 10 + 1;
    localparam int BCD_W  = 4 * BCD_N;
    localparam int DISP_W = 4 * DIGITS;
    localparam int CNT_W  = $clog2(DATA_WIDTH + 1);
    localparam int PRE_W  = $clog2(REFRESH_DIV);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_WIDTH - 1);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    localparam logic [6:0] GLYPH_DASH = 7'h40;

    // ------------------------------------------------------------------
    // Converter FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } conv_state_t;

    conv_state_t state;
    conv_state_t state_next;

    logic [DATA_WIDTH-1:0] value_sr;   // captured value, shifted out MSB first
    logic                  hex_r;      // captured display mode
    logic [BCD_W-1:0]      bcd;        // double-dabble accumulator
    logic [BCD_W-1:0]      bcd_adj;    // accumulator after the add-3 correction
    logic [BCD_W-1:0]      bcd_next;   // accumulator after one full step
    logic [CNT_W-1:0]      step_cnt;

    logic [DISP_W-1:0]     disp;       // display register, nibble per position
    logic                  ovf;        // display register overflow flag
    logic [DISP_W-1:0]     disp_new;
    logic                  ovf_new;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (load) begin
                    state_next = hex_mode ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (step_cnt == LAST_STEP) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE);

    // ------------------------------------------------------------------
    // Double-dabble step: correct every nibble >= 5, then shift in the
    // next value bit. The correction keeps each nibble a valid BCD digit
    // after the doubling implied by the shift.
    // ------------------------------------------------------------------
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < BCD_N; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4];
            end
        end
    end

    // The top accumulator bit is shifted out; sizing guarantees it is zero.
    assign bcd_next = BCD_W'({bcd_adj, value_sr[DATA_WIDTH-1]});

    // ------------------------------------------------------------------
    // Display register content and overflow, evaluated in DONE.
    // Hex nibbles are the value zero-extended (or truncated) to the
    // display width; anything that does not fit raises the overflow.
    // ------------------------------------------------------------------
    always_comb begin
        disp_new = '0;
        ovf_new  = 1'b0;
        if (hex_r) begin
            disp_new = DISP_W'(value_sr);
            ovf_new  = ((value_sr >> DISP_W) != '0);
        end else begin
            disp_new = DISP_W'(bcd);
            ovf_new  = ((bcd >> DISP_W) != '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_sr <= '0;
            hex_r    <= 1'b0;
            bcd      <= '0;
            step_cnt <= '0;
            disp     <= '0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load) begin
                        value_sr <= value;
                        hex_r    <= hex_mode;
                        bcd      <= '0;
                        step_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    bcd      <= bcd_next;
                    value_sr <= value_sr << 1;
                    step_cnt <= step_cnt + 1'b1;
                end
                S_DONE: begin
                    disp <= disp_new;
                    ovf  <= ovf_new;
                end
                default: begin
                    disp <= disp;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Glyph table, active-high {g,f,e,d,c,b,a}
    // ------------------------------------------------------------------
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'h3F;
            4'h1:    g = 7'h06;
            4'h2:    g = 7'h5B;
            4'h3:    g = 7'h4F;
            4'h4:    g = 7'h66;
            4'h5:    g = 7'h6D;
            4'h6:    g = 7'h7D;
            4'h7:    g = 7'h07;
            4'h8:    g = 7'h7F;
            4'h9:    g = 7'h6F;
            4'hA:    g = 7'h77;
            4'hB:    g = 7'h7C;
            4'hC:    g = 7'h39;
            4'hD:    g = 7'h5E;
            4'hE:    g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    // ------------------------------------------------------------------
    // Leading-zero blanking: walk from the top position down, tracking
    // whether this nibble and everything above it is zero.
    // ------------------------------------------------------------------
    logic [DIGITS-1:0] blank_vec;

    always_comb begin
        logic zero_run;
        blank_vec = '0;
        zero_run  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (disp[4*i +: 4] == 4'h0);
            if (i != 0) begin
                blank_vec[i] = blank_zeros & zero_run & ~ovf;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan: prescaler and position index. The pattern for the position
    // about to be selected is computed ahead so that the select and the
    // segments are registered on the same edge.
    // ------------------------------------------------------------------
    logic [PRE_W-1:0]  prescaler;
    logic [IDX_W-1:0]  scan_idx;
    logic [IDX_W-1:0]  scan_next;
    logic [7:0]        seg_next;
    logic [DIGITS-1:0] dig_next;
    logic [7:0]        seg_r;
    logic [DIGITS-1:0] dig_r;

    assign scan_next = (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;

    always_comb begin
        logic [6:0] glyph;
        if (ovf) begin
            glyph = GLYPH_DASH;
        end else if (blank_vec[scan_next]) begin
            glyph = 7'h00;
        end else begin
            glyph = hex_glyph(disp[4*scan_next +: 4]);
        end
        seg_next = {dp_mask[scan_next], glyph};
    end

    always_comb begin
        dig_next            = '0;
        dig_next[scan_next] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
            scan_idx  <= IDX_LAST;
            seg_r     <= '0;
            dig_r     <= '0;
        end else begin
            if (prescaler == PRE_LAST) begin
                prescaler <= '0;
                scan_idx  <= scan_next;
                seg_r     <= seg_next;
                dig_r     <= dig_next;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

    // Polarity is a constant XOR after the output register.
    assign sseg_indicator = seg_r ^ {8{SEG_ACTIVE_LOW}};
    assign digits         = dig_r ^ {DIGITS{DIG_ACTIVE_LOW}};

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sseg_scan_display
//  Description : Self-checking bench for sseg_scan_display. Two instances:
//                A with DIGITS=4, B with DIGITS=2, both REFRESH_DIV=4.
//                Expected scan patterns are queued by the stimulus and
//                popped by monitors whenever the digit select changes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sseg_scan_display;

    logic clk;
    logic reset;

    logic [8:0] a_value, b_value;
    logic       a_load, b_load, a_hex, b_hex, a_blank, b_blank;
    logic [3:0] a_dp;
    logic [1:0] b_dp;
    logic       a_busy, b_busy;
    logic [7:0] a_sseg, b_sseg;
    logic [3:0] a_digits;
    logic [1:0] b_digits;

    int checks   = 0;
    int failures = 0;

    logic [15:0] q_a[$];
    logic [15:0] q_b[$];
    logic [15:0] e_a, e_b;
    logic [3:0]  prev_a = '0;
    logic [1:0]  prev_b = '0;

    sseg_scan_display #(
        .DATA_WIDTH(9), .DIGITS(4), .REFRESH_DIV(4),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b0)
    ) u_dut_a (
        .clk(clk), .reset(reset), .value(a_value), .load(a_load),
        .hex_mode(a_hex), .blank_zeros(a_blank), .dp_mask(a_dp),
        .busy(a_busy), .sseg_indicator(a_sseg), .digits(a_digits)
    );

    sseg_scan_display #(
        .DATA_WIDTH(9), .DIGITS(2), .REFRESH_DIV(4),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b0)
    ) u_dut_b (
        .clk(clk), .reset(reset), .value(b_value), .load(b_load),
        .hex_mode(b_hex), .blank_zeros(b_blank), .dp_mask(b_dp),
        .busy(b_busy), .sseg_indicator(b_sseg), .digits(b_digits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitors: each change of the digit select is one displayed slot.
    always @(negedge clk) begin
        if (a_digits !== prev_a) begin
            if (a_digits != '0 && q_a.size() > 0) begin
                e_a = q_a.pop_front();
                chk("scan_a_digits", 32'(a_digits), 32'(e_a[15:8]));
                chk("scan_a_sseg", 32'(a_sseg), 32'(e_a[7:0]));
            end
            prev_a = a_digits;
        end
    end

    always @(negedge clk) begin
        if (b_digits !== prev_b) begin
            if (b_digits != '0 && q_b.size() > 0) begin
                e_b = q_b.pop_front();
                chk("scan_b_digits", 32'(b_digits), 32'(e_b[15:8]));
                chk("scan_b_sseg", 32'(b_sseg), 32'(e_b[7:0]));
            end
            prev_b = b_digits;
        end
    end

    function automatic logic [7:0] cur_dig(input int sel);
        return (sel == 0) ? 8'(a_digits) : 8'(b_digits);
    endfunction

    function automatic int qsize(input int sel);
        return (sel == 0) ? q_a.size() : q_b.size();
    endfunction

    // Issue a load and count the cycles busy stays high.
    task automatic do_load(input int sel, input logic [8:0] v, input logic h, output int bc);
        @(posedge clk); #1;
        if (sel == 0) begin a_value = v; a_hex = h; a_load = 1'b1; end
        else          begin b_value = v; b_hex = h; b_load = 1'b1; end
        @(posedge clk); #1;
        a_load = 1'b0;
        b_load = 1'b0;
        bc = 0;
        while (((sel == 0) ? a_busy : b_busy) && bc < 100) begin
            bc++;
            @(posedge clk); #1;
        end
    endtask

    // Queue one full scan cycle starting at position 0 and wait for it.
    task automatic expect_scan(input int sel, input logic [7:0] s0, input logic [7:0] s1,
                               input logic [7:0] s2, input logic [7:0] s3);
        logic [7:0] exp_s [4];
        int n;
        int cyc;
        exp_s[0] = s0; exp_s[1] = s1; exp_s[2] = s2; exp_s[3] = s3;
        n = (sel == 0) ? 4 : 2;
        for (int i = 0; i < n; i++) begin
            if (sel == 0) q_a.push_back({8'(1 << i), exp_s[i]});
            else          q_b.push_back({8'(1 << i), exp_s[i]});
        end
        cyc = 0;
        while (qsize(sel) != 0 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("scan_drain", 32'(qsize(sel)), 32'd0);
        q_a.delete();
        q_b.delete();
    endtask

    // Wait for a fresh entry into the last position so the next slot is 0.
    task automatic show(input int sel, input logic [7:0] s0, input logic [7:0] s1,
                        input logic [7:0] s2, input logic [7:0] s3);
        logic [7:0] last;
        int cyc;
        last = (sel == 0) ? 8'h08 : 8'h02;
        cyc = 0;
        while (cur_dig(sel) == last && cyc < 200) begin @(posedge clk); #1; cyc++; end
        while (cur_dig(sel) != last && cyc < 200) begin @(posedge clk); #1; cyc++; end
        @(negedge clk); #1;
        expect_scan(sel, s0, s1, s2, s3);
    endtask

    initial begin
        int bc;
        reset   = 1'b0;
        a_value = '0; b_value = '0;
        a_load  = 1'b0; b_load = 1'b0;
        a_hex   = 1'b0; b_hex  = 1'b0;
        a_blank = 1'b0; b_blank = 1'b0;
        a_dp    = '0;   b_dp    = '0;

        // Reset state
        #3;
        chk("rst_digits", 32'(a_digits), 32'h0);
        chk("rst_sseg", 32'(a_sseg), 32'hFF);
        chk("rst_busy", 32'(a_busy), 32'h0);
        chk("rst_b_sseg", 32'(b_sseg), 32'hFF);

        // First slot appears REFRESH_DIV edges after release
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_first_slot_digits", 32'(a_digits), 32'h0);
        @(posedge clk); #1;
        chk("first_slot_digits", 32'(a_digits), 32'h1);
        chk("first_slot_sseg", 32'(a_sseg), 32'hC0);

        // Decimal 317 with blanking
        a_blank = 1'b1;
        do_load(0, 9'd317, 1'b0, bc);
        chk("busy_dec_317", 32'(bc), 32'd10);
        show(0, 8'hF8, 8'hF9, 8'hB0, 8'hFF);

        // Hex 1AF, no blanking
        a_blank = 1'b0;
        do_load(0, 9'h1AF, 1'b1, bc);
        chk("busy_hex_1af", 32'(bc), 32'd1);
        show(0, 8'h8E, 8'h88, 8'hF9, 8'hC0);

        // Overflow, two positions
        do_load(1, 9'd100, 1'b0, bc);
        chk("busy_b_dec_100", 32'(bc), 32'd10);
        show(1, 8'hBF, 8'hBF, 8'h00, 8'h00);
        do_load(1, 9'h100, 1'b1, bc);
        chk("busy_b_hex_100", 32'(bc), 32'd1);
        show(1, 8'hBF, 8'hBF, 8'h00, 8'h00);
        do_load(1, 9'd99, 1'b0, bc);
        show(1, 8'h90, 8'h90, 8'h00, 8'h00);

        // Load collision: second load during conversion is dropped
        a_blank = 1'b1;
        do_load(0, 9'd0, 1'b0, bc);
        @(posedge clk); #1;
        a_value = 9'd317; a_hex = 1'b0; a_load = 1'b1;
        @(posedge clk); #1;
        a_load = 1'b0;
        @(posedge clk); #1;
        a_value = 9'd5; a_load = 1'b1;
        @(posedge clk); #1;
        a_load = 1'b0;
        bc = 0;
        while (a_busy && bc < 100) begin bc++; @(posedge clk); #1; end
        chk("busy_collision_rest", 32'(bc), 32'd8);
        show(0, 8'hF8, 8'hF9, 8'hB0, 8'hFF);

        // Reset mid-conversion
        @(posedge clk); #1;
        a_value = 9'd5; a_load = 1'b1;
        @(posedge clk); #1;
        a_load = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("busy_mid_conv", 32'(a_busy), 32'h1);
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(a_busy), 32'h0);
        chk("abort_digits", 32'(a_digits), 32'h0);
        chk("abort_sseg", 32'(a_sseg), 32'hFF);
        @(negedge clk);
        reset = 1'b1;
        expect_scan(0, 8'hC0, 8'hFF, 8'hFF, 8'hFF);

        // Zero with blanking and a decimal point on a blanked position
        a_dp = 4'b0100;
        do_load(0, 9'd0, 1'b0, bc);
        show(0, 8'hC0, 8'hFF, 8'h7F, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
